dsp: RTL and testbench



---
 rtl/dsp_pkg.sv | 53 +++++
 rtl/dsp_if.sv | 33 +++
 rtl/dsp_alu.sv | 118 +++++++++++
 rtl/dsp.sv | 105 ++++++++++
 tb/tb_dsp.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared widths and control encodings for the dsp slice
package dsp_pkg;

    localparam int A_W  = 30;   // operand A
    localparam int B_W  = 18;   // operand B
    localparam int P_W  = 48;   // C, P and ALU datapath
    localparam int AD_W = 25;   // pre-adder result and D
    localparam int M_W  = 43;   // native 25x18 product

    // Arithmetic right shift applied to P on the Z_PSHIFT path
    localparam int SHIFT_Z = 17;

    // INMODE bit indices (bits 0 and 4 have no function)
    localparam int INMODE_ZERO_A = 1;
    localparam int INMODE_USE_D  = 2;
    localparam int INMODE_SUB    = 3;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_AB   = 2'b11
    } xmux_e;

    typedef enum logic [1:0] {
        Y_ZERO = 2'b00,
        Y_M    = 2'b01,
        Y_ONES = 2'b10,
        Y_C    = 2'b11
    } ymux_e;

    typedef enum logic [2:0] {
        Z_ZERO   = 3'b000,
        Z_P      = 3'b010,
        Z_C      = 3'b011,
        Z_PSHIFT = 3'b101
    } zmux_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_NEGZ   = 4'b0001,
        ALU_NOTADD = 4'b0010,
        ALU_ZSUB   = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_XNOR   = 4'b0101,
        ALU_AND    = 4'b1100,
        ALU_OR     = 4'b1110
    } alumode_e;

    // X/Y code pair that routes M into the sum exactly once
    localparam logic [3:0] OPMODE_XY_M = 4'b0101;

endpackage

// File: rtl/dsp_if.sv
// rtl/dsp_if.sv - operand/control/result bundle of the dsp slice
// Signals:
//   A, B, C, D     operands (A 30b, B 18b signed, C 48b, D 25b signed)
//   CIN            ALU carry-in
//   OPMODE         [1:0] X mux, [3:2] Y mux, [6:4] Z mux
//   ALUMODE        ALU function select
//   INMODE         pre-adder control
//   P, COUT        registered result and carry/overflow flags
interface dsp_if;
    import dsp_pkg::*;

    logic [A_W-1:0]  A;
    logic [B_W-1:0]  B;
    logic [P_W-1:0]  C;
    logic [AD_W-1:0] D;
    logic            CIN;
    logic [6:0]      OPMODE;
    logic [3:0]      ALUMODE;
    logic [4:0]      INMODE;
    logic [4:0]      COUT;
    logic [P_W-1:0]  P;

    modport master (
        output A, B, C, D, CIN, OPMODE, ALUMODE, INMODE,
        input  COUT, P
    );

    modport slave (
        input  A, B, C, D, CIN, OPMODE, ALUMODE, INMODE,
        output COUT, P
    );

endinterface

// File: rtl/dsp_alu.sv
// rtl/dsp_alu.sv - X/Y/Z operand muxes, 48-bit ALU and carry/overflow flags
// Ports:
//   opmode_i   X/Y/Z mux selects
//   alumode_i  ALU function
//   m_i        sign-extended product
//   ab_i       A:B concatenation
//   c_i        operand C
//   p_i        currently registered P (feedback)
//   cin_i      carry-in
//   p_o        next P
//   cout_o     next COUT: [3:0] carries out of bits 11/23/35/47, [4] overflow
module dsp_alu
    import dsp_pkg::*;
(
    input  logic [6:0]     opmode_i,
    input  logic [3:0]     alumode_i,
    input  logic [P_W-1:0] m_i,
    input  logic [P_W-1:0] ab_i,
    input  logic [P_W-1:0] c_i,
    input  logic [P_W-1:0] p_i,
    input  logic           cin_i,
    output logic [P_W-1:0] p_o,
    output logic [4:0]     cout_o
);

    logic [P_W-1:0] x, y, z, xy, w, op_a, op_b;
    logic           op_c;
    logic [P_W:0]   sum;
    logic [3:0]     carries;
    logic           ovf;

    always_comb begin
        x = '0;
        y = '0;
        z = '0;

        // The product is only summed when both X and Y ask for it; it is
        // routed through X and Y contributes nothing.
        case (opmode_i[1:0])
            X_M:     x = (opmode_i[3:0] == OPMODE_XY_M) ? m_i : '0;
            X_P:     x = p_i;
            X_AB:    x = ab_i;
            default: x = '0;
        endcase

        case (opmode_i[3:2])
            Y_ONES:  y = '1;
            Y_C:     y = c_i;
            default: y = '0;
        endcase

        case (opmode_i[6:4])
            Z_P:      z = p_i;
            Z_C:      z = c_i;
            Z_PSHIFT: z = P_W'($signed(p_i) >>> SHIFT_Z);
            default:  z = '0;
        endcase

        xy = x + y;
        w  = xy + P_W'(cin_i);

        // All arithmetic modes share one two-operand adder; flags come from it.
        case (alumode_i)
            ALU_ZSUB: begin                 // Z - W = Z + ~W + 1
                op_a = z;
                op_b = ~w;
                op_c = 1'b1;
            end
            ALU_NEGZ: begin                 // -Z + W - 1 = ~Z + W
                op_a = ~z;
                op_b = w;
                op_c = 1'b0;
            end
            default: begin
                op_a = z;
                op_b = xy;
                op_c = cin_i;
            end
        endcase

        sum = {1'b0, op_a} + {1'b0, op_b} + {{P_W{1'b0}}, op_c};

        // Carry into bit k+1 recovered from sum ^ a ^ b at that bit.
        carries[0] = sum[12] ^ op_a[12] ^ op_b[12];
        carries[1] = sum[24] ^ op_a[24] ^ op_b[24];
        carries[2] = sum[36] ^ op_a[36] ^ op_b[36];
        carries[3] = sum[P_W];
        ovf        = (op_a[P_W-1] == op_b[P_W-1]) && (sum[P_W-1] != op_a[P_W-1]);

        case (alumode_i)
            ALU_XOR: begin
                p_o    = x ^ z;
                cout_o = '0;
            end
            ALU_XNOR: begin
                p_o    = ~(x ^ z);
                cout_o = '0;
            end
            ALU_AND: begin
                p_o    = x & z;
                cout_o = '0;
            end
            ALU_OR: begin
                p_o    = x | z;
                cout_o = '0;
            end
            ALU_NOTADD: begin
                p_o    = ~sum[P_W-1:0];
                cout_o = {ovf, carries};
            end
            default: begin
                p_o    = sum[P_W-1:0];
                cout_o = {ovf, carries};
            end
        endcase
    end

endmodule

// File: rtl/dsp.sv
// rtl/dsp.sv - three-stage DSP slice: input regs, pre-adder/multiplier, ALU
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears every pipeline stage
//   dsp_bus  slave side of dsp_if: operands and controls in, P/COUT out
module dsp
    import dsp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    dsp_if.slave dsp_bus
);

    // Stage 1: input registers
    logic [A_W-1:0]  a1_q;
    logic [B_W-1:0]  b1_q;
    logic [P_W-1:0]  c1_q;
    logic [AD_W-1:0] d1_q;
    logic            cin1_q;
    logic [6:0]      opmode1_q;
    logic [3:0]      alumode1_q;
    logic [3:1]      inmode1_q;

    // Stage 2: product plus the fields that travel with it
    logic [P_W-1:0]  m2_q, m2_d;
    logic [P_W-1:0]  ab2_q;
    logic [P_W-1:0]  c2_q;
    logic            cin2_q;
    logic [6:0]      opmode2_q;
    logic [3:0]      alumode2_q;

    // Stage 3: result
    logic [P_W-1:0]  p_q, p_d;
    logic [4:0]      cout_q, cout_d;

    // INMODE[0] and INMODE[4] have no function in this slice.
    logic unused_inmode;
    assign unused_inmode = dsp_bus.INMODE[0] ^ dsp_bus.INMODE[4];

    logic signed [AD_W-1:0] a_term, d_term, ad;
    logic signed [M_W-1:0]  m_prod;

    always_comb begin
        a_term = inmode1_q[INMODE_ZERO_A] ? '0 : $signed(a1_q[AD_W-1:0]);
        d_term = inmode1_q[INMODE_USE_D]  ? $signed(d1_q) : '0;
        ad     = inmode1_q[INMODE_SUB]    ? (d_term - a_term) : (d_term + a_term);
        // Both factors sign-extended to 43 bits; the product always fits.
        m_prod = M_W'(ad) * M_W'($signed(b1_q));
        m2_d   = {{(P_W - M_W){m_prod[M_W-1]}}, m_prod};
    end

    dsp_alu u_alu (
        .opmode_i  (opmode2_q),
        .alumode_i (alumode2_q),
        .m_i       (m2_q),
        .ab_i      (ab2_q),
        .c_i       (c2_q),
        .p_i       (p_q),
        .cin_i     (cin2_q),
        .p_o       (p_d),
        .cout_o    (cout_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q       <= '0;
            b1_q       <= '0;
            c1_q       <= '0;
            d1_q       <= '0;
            cin1_q     <= 1'b0;
            opmode1_q  <= '0;
            alumode1_q <= '0;
            inmode1_q  <= '0;
            m2_q       <= '0;
            ab2_q      <= '0;
            c2_q       <= '0;
            cin2_q     <= 1'b0;
            opmode2_q  <= '0;
            alumode2_q <= '0;
            p_q        <= '0;
            cout_q     <= '0;
        end else begin
            a1_q       <= dsp_bus.A;
            b1_q       <= dsp_bus.B;
            c1_q       <= dsp_bus.C;
            d1_q       <= dsp_bus.D;
            cin1_q     <= dsp_bus.CIN;
            opmode1_q  <= dsp_bus.OPMODE;
            alumode1_q <= dsp_bus.ALUMODE;
            inmode1_q  <= dsp_bus.INMODE[3:1];
            m2_q       <= m2_d;
            ab2_q      <= {a1_q, b1_q};
            c2_q       <= c1_q;
            cin2_q     <= cin1_q;
            opmode2_q  <= opmode1_q;
            alumode2_q <= alumode1_q;
            p_q        <= p_d;
            cout_q     <= cout_d;
        end
    end

    assign dsp_bus.P    = p_q;
    assign dsp_bus.COUT = cout_q;

endmodule

// File: tb/tb_dsp.sv
// tb/tb_dsp.sv - directed-vector bench for dsp with a behavioural reference model
module tb_dsp;

    typedef struct packed {
        logic [29:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [24:0] d;
        logic        cin;
        logic [6:0]  opmode;
        logic [3:0]  alumode;
        logic [4:0]  inmode;
    } vec_t;

    localparam logic [63:0] MASK48 = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint MAX_S48 = 64'sd140737488355327;
    localparam longint MIN_S48 = -64'sd140737488355328;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_if bus();

    dsp u_dut (
        .clk     (clk),
        .rst     (rst),
        .dsp_bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference state: result after the latest edge plus the two vectors in flight.
    logic [47:0] m_p;
    logic [4:0]  m_cout;
    vec_t        m_s1, m_s2;

    function automatic vec_t mk(input logic [29:0] a, input logic [17:0] b,
                                input logic [47:0] c, input logic [24:0] d,
                                input logic cin, input logic [6:0] opm,
                                input logic [3:0] alum, input logic [4:0] inm);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.d = d; v.cin = cin;
        v.opmode = opm; v.alumode = alum; v.inmode = inm;
        return v;
    endfunction

    // Result of one operation from its inputs and the P it sees, by plain arithmetic.
    function automatic void model_eval(input vec_t v, input logic [47:0] p_prev,
                                       output logic [47:0] r, output logic [4:0] co);
        logic signed [24:0] a25, d25, ad25;
        logic signed [17:0] b18;
        logic signed [47:0] ps, t48;
        longint aterm, dterm, ad, m, sa, sb, tot;
        logic [63:0] x, y, z, xy, w, opa, opb, opc, sum, lim;
        bit is_logic;
        a25 = v.a[24:0];
        d25 = v.d;
        b18 = v.b;
        aterm = v.inmode[1] ? 64'sd0 : longint'(a25);
        dterm = v.inmode[2] ? longint'(d25) : 64'sd0;
        ad = v.inmode[3] ? dterm - aterm : dterm + aterm;
        ad25 = ad[24:0];
        m = longint'(ad25) * longint'(b18);

        x = 64'd0;
        if (v.opmode[3:0] == 4'b0101) begin
            x = m;
            x = x & MASK48;
        end else if (v.opmode[1:0] == 2'b10) x = {16'd0, p_prev};
        else if (v.opmode[1:0] == 2'b11)   x = {16'd0, v.a, v.b};

        y = 64'd0;
        if (v.opmode[3:2] == 2'b10)      y = MASK48;
        else if (v.opmode[3:2] == 2'b11) y = {16'd0, v.c};

        z = 64'd0;
        ps = p_prev;
        if (v.opmode[6:4] == 3'b010)      z = {16'd0, p_prev};
        else if (v.opmode[6:4] == 3'b011) z = {16'd0, v.c};
        else if (v.opmode[6:4] == 3'b101) z = 64'(ps >>> 17) & MASK48;

        xy = (x + y) & MASK48;
        w  = (xy + {63'd0, v.cin}) & MASK48;
        is_logic = 1'b0;
        r = '0;
        co = '0;
        opa = z; opb = xy; opc = {63'd0, v.cin};
        case (v.alumode)
            4'b0011: begin opa = z; opb = MASK48 - w; opc = 64'd1; end
            4'b0001: begin opa = MASK48 - z; opb = w; opc = 64'd0; end
            4'b0100: begin is_logic = 1'b1; r = 48'(x ^ z); end
            4'b0101: begin is_logic = 1'b1; r = ~48'(x ^ z); end
            4'b1100: begin is_logic = 1'b1; r = 48'(x & z); end
            4'b1110: begin is_logic = 1'b1; r = 48'(x | z); end
            default: ;
        endcase
        if (!is_logic) begin
            sum = opa + opb + opc;
            r = sum[47:0];
            if (v.alumode == 4'b0010) r = ~r;
            for (int i = 0; i < 4; i++) begin
                lim = 64'd1 << (12 * i + 12);
                co[i] = ((opa % lim) + (opb % lim) + opc) >= lim;
            end
            t48 = opa[47:0]; sa = t48;
            t48 = opb[47:0]; sb = t48;
            tot = sa + sb + longint'(opc);
            co[4] = (tot > MAX_S48) || (tot < MIN_S48);
        end
    endfunction

    always @(posedge clk) begin
        logic [47:0] np;
        logic [4:0]  nc;
        if (rst) begin
            m_p = '0; m_cout = '0; m_s1 = '0; m_s2 = '0;
        end else begin
            model_eval(m_s2, m_p, np, nc);
            m_p = np;
            m_cout = nc;
            m_s2 = m_s1;
            m_s1 = mk(bus.A, bus.B, bus.C, bus.D, bus.CIN, bus.OPMODE, bus.ALUMODE, bus.INMODE);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (bus.P !== m_p || bus.COUT !== m_cout) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: P=%h COUT=%b, required P=%h COUT=%b",
                         $time, bus.P, bus.COUT, m_p, m_cout);
            end
        end
    end

    task automatic set_inputs(input vec_t v, input logic r);
        rst = r;
        bus.A = v.a; bus.B = v.b; bus.C = v.c; bus.D = v.d; bus.CIN = v.cin;
        bus.OPMODE = v.opmode; bus.ALUMODE = v.alumode; bus.INMODE = v.inmode;
    endtask

    task automatic drive(input vec_t v, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_inputs(v, r);
        end
    endtask

    task automatic lit(input string name, input logic [47:0] ep, input logic [4:0] ec);
        n_vec++;
        if (bus.P !== ep || bus.COUT !== ec) begin
            n_fail++;
            $display("FAIL %s: P=%h COUT=%b, required P=%h COUT=%b", name, bus.P, bus.COUT, ep, ec);
        end
        n_vec++;
        if (m_p !== ep || m_cout !== ec) begin
            n_fail++;
            $display("FAIL %s_model: P=%h COUT=%b, required P=%h COUT=%b", name, m_p, m_cout, ep, ec);
        end
    endtask

    initial begin
        vec_t idle, vmul, vmadd, vpre, vcarry, vacc;
        vec_t tbl[20];

        idle   = '0;
        vmul   = mk(30'h0A, 18'h009, 48'd0, 25'd0, 1'b0, 7'b0000101, 4'b0000, 5'b00000);
        vmadd  = mk(30'd3, 18'h3FFFE, 48'd100, 25'd0, 1'b0, 7'b0110101, 4'b0000, 5'b00000);
        vpre   = mk(30'd5, 18'd4, 48'd0, 25'd20, 1'b0, 7'b0000101, 4'b0000, 5'b01100);
        vcarry = mk(30'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 25'd0, 1'b1, 7'b0110000, 4'b0000, 5'b00000);
        vacc   = mk(30'd1, 18'd1, 48'd0, 25'd0, 1'b0, 7'b0100101, 4'b0000, 5'b00000);

        tbl[0]  = mk(30'h0123_4567, 18'h02345, 48'h1000_0000_0000, 25'd0, 1'b1, 7'b0110011, 4'b0011, 5'b0);
        tbl[1]  = mk(30'd7, 18'd9, 48'h0000_0000_1234, 25'd0, 1'b1, 7'b0111100, 4'b0001, 5'b0);
        tbl[2]  = mk(30'd3, 18'h3FF00, 48'd0, 25'h1000, 1'b0, 7'b0100101, 4'b0010, 5'b00100);
        tbl[3]  = mk(30'h2AAA_AAAA, 18'h15555, 48'h0F0F_0F0F_0F0F, 25'd0, 1'b0, 7'b0110011, 4'b0100, 5'b0);
        tbl[4]  = mk(30'h2AAA_AAAA, 18'h15555, 48'h0F0F_0F0F_0F0F, 25'd0, 1'b0, 7'b0110011, 4'b0101, 5'b0);
        tbl[5]  = mk(30'h2AAA_AAAA, 18'h15555, 48'h0F0F_0F0F_0F0F, 25'd0, 1'b0, 7'b0110011, 4'b1100, 5'b0);
        tbl[6]  = mk(30'h2AAA_AAAA, 18'h15555, 48'h0F0F_0F0F_0F0F, 25'd0, 1'b0, 7'b0110011, 4'b1110, 5'b0);
        tbl[7]  = mk(30'd10, 18'd10, 48'd5, 25'd0, 1'b1, 7'b0110101, 4'b0111, 5'b0);
        tbl[8]  = mk(30'd0, 18'd0, 48'd0, 25'd0, 1'b1, 7'b0001000, 4'b0000, 5'b0);
        tbl[9]  = mk(30'd1000, 18'd1000, 48'd0, 25'd0, 1'b0, 7'b1010101, 4'b0000, 5'b0);
        tbl[10] = mk(30'd0, 18'd0, 48'd0, 25'd0, 1'b0, 7'b0100010, 4'b0000, 5'b0);
        tbl[11] = mk(30'd0, 18'd1, 48'h7FFF_FFFF_FFFF, 25'd0, 1'b0, 7'b0110011, 4'b0000, 5'b0);
        tbl[12] = mk(30'd0, 18'd0, 48'h8000_0000_0000, 25'd0, 1'b0, 7'b0111000, 4'b0000, 5'b0);
        tbl[13] = mk(30'd100, 18'd3, 48'd0, 25'd7, 1'b0, 7'b0000101, 4'b0000, 5'b00110);
        tbl[14] = mk(30'd6, 18'd5, 48'd0, 25'd2, 1'b0, 7'b0000101, 4'b0000, 5'b10001);
        tbl[15] = mk(30'd1, 18'd2, 48'd0, 25'h0FF_FFFF, 1'b0, 7'b0000101, 4'b0000, 5'b00100);
        tbl[16] = mk(30'h100_0000, 18'h20000, 48'd0, 25'd0, 1'b0, 7'b0000101, 4'b0000, 5'b0);
        tbl[17] = mk(30'd1, 18'd1, 48'd50, 25'd0, 1'b0, 7'b0110101, 4'b1001, 5'b0);
        tbl[18] = mk(30'd5, 18'd5, 48'd0, 25'd0, 1'b0, 7'b0000100, 4'b0000, 5'b0);
        tbl[19] = mk(30'd5, 18'd5, 48'd0, 25'd0, 1'b0, 7'b0000001, 4'b0000, 5'b0);

        set_inputs(idle, 1'b1);
        drive(idle, 1'b1, 2);
        chk_en = 1'b1;
        lit("reset", 48'd0, 5'b00000);

        drive(vmul, 1'b0, 4);
        lit("mul", 48'h0000_0000_005A, 5'b00000);
        drive(vmul, 1'b0, 1);
        lit("mul_hold", 48'h0000_0000_005A, 5'b00000);

        drive(vmadd, 1'b0, 4);
        lit("mul_add", 48'd94, 5'b01111);

        drive(vpre, 1'b0, 4);
        lit("preadd_sub", 48'd60, 5'b00000);

        drive(vcarry, 1'b0, 4);
        lit("carry_wrap", 48'd0, 5'b01111);

        drive(vacc, 1'b1, 1);
        drive(vacc, 1'b0, 4);
        lit("acc1", 48'd1, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("acc2", 48'd2, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("acc3", 48'd3, 5'b00000);
        drive(vacc, 1'b0, 2);
        lit("acc5", 48'd5, 5'b00000);

        drive(vacc, 1'b1, 1);
        drive(vacc, 1'b0, 1);
        lit("rst_mid", 48'd0, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("rst_mid_e2", 48'd0, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("rst_mid_e3", 48'd0, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("restart1", 48'd1, 5'b00000);
        drive(vacc, 1'b0, 1);
        lit("restart2", 48'd2, 5'b00000);

        for (int i = 0; i < 20; i++) drive(tbl[i], 1'b0, 1);
        drive(idle, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
